// File: rtl/datapath_pipe_unit_pkg.sv
// Shared definitions for the two-stage 16-bit RISC datapath: instruction
// field positions, ALU function codes and fetch constants.
package datapath_pipe_unit_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_STEP = 2;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int RS1_HI = 11;
    localparam int RS1_LO = 9;
    localparam int RS2_HI = 8;
    localparam int RS2_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int IMM_HI = 5;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

endpackage

// File: rtl/datapath_regfile.sv
// 8-entry register file: two asynchronous read ports, one synchronous write
// port, asynchronous active-low clear.
module datapath_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [2:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/datapath_pipe_unit.sv
// Two-stage (fetch / execute) 16-bit RISC datapath with input/output port
// handshakes, a data-memory ready stall and jne branches that flush the fetch slot.
module datapath_pipe_unit
    import datapath_pipe_unit_pkg::*;
#(
    parameter int              DATA_W   = 8,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jump_neq,
    input  logic              write_strobe,
    input  logic              read_strobe,
    input  logic              rom_read,
    input  logic              rom_write,
    input  logic              alu_select,
    input  logic              sel_dst_reg,
    input  logic              rom_to_reg,
    input  logic              write_reg,
    input  logic [1:0]        output_ALU,
    output logic [2:0]        opcode,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_data,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_re,
    output logic              dmem_we,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              stall
);

    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    ir_pc;
    logic [INSTR_W-1:0] ir;
    logic               ir_valid;

    logic [2:0]         rs1_addr;
    logic [2:0]         rs2_addr;
    logic [2:0]         dest_addr;
    logic signed [5:0]  imm6;
    logic [DATA_W-1:0]  imm_ext;
    logic [DATA_W-1:0]  rs1_data;
    logic [DATA_W-1:0]  rs2_data;
    logic [DATA_W-1:0]  op_b;
    logic [DATA_W-1:0]  alu_result;
    logic               zero;

    logic q_jump_neq, q_write_strobe, q_read_strobe, q_rom_read, q_rom_write, q_write_reg;
    logic in_wait, mem_wait, out_wait, stall_other;
    logic branch_taken, out_accept, wb_en;
    logic [DATA_W-1:0]  wb_data;
    logic [PC_W-1:0]    branch_target;
    logic               unused_ir_bit;

    assign rs1_addr  = ir[RS1_HI:RS1_LO];
    assign rs2_addr  = ir[RS2_HI:RS2_LO];
    assign dest_addr = sel_dst_reg ? ir[RD_HI:RD_LO] : ir[RS2_HI:RS2_LO];
    assign imm6      = ir[IMM_HI:IMM_LO];
    assign imm_ext   = DATA_W'(imm6);
    assign unused_ir_bit = ir[12];

    // A bubble in EX must not act on whatever the decoder presents for it.
    assign q_jump_neq     = ir_valid & jump_neq;
    assign q_write_strobe = ir_valid & write_strobe;
    assign q_read_strobe  = ir_valid & read_strobe;
    assign q_rom_read     = ir_valid & rom_read;
    assign q_rom_write    = ir_valid & rom_write;
    assign q_write_reg    = ir_valid & write_reg;

    assign in_wait     = q_read_strobe & ~in_valid;
    assign mem_wait    = (q_rom_read | q_rom_write) & ~dmem_ready;
    assign out_wait    = q_write_strobe & out_valid & ~out_ready;
    assign stall_other = mem_wait | out_wait;
    assign stall       = in_wait | stall_other;

    datapath_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_a (rs1_addr),
        .rdata_a (rs1_data),
        .raddr_b (rs2_addr),
        .rdata_b (rs2_data),
        .we      (wb_en),
        .waddr   (dest_addr),
        .wdata   (wb_data)
    );

    assign op_b = alu_select ? imm_ext : rs2_data;

    always_comb begin
        alu_result = '0;
        case (alu_op_e'(output_ALU))
            ALU_ADD: alu_result = rs1_data + op_b;
            ALU_SUB: alu_result = rs1_data - op_b;
            ALU_AND: alu_result = rs1_data & op_b;
            default: alu_result = rs1_data | op_b;
        endcase
    end

    assign zero = (alu_result == '0);

    always_comb begin
        wb_data = alu_result;
        if (read_strobe) begin
            wb_data = in_data;
        end else if (rom_to_reg) begin
            wb_data = dmem_rdata;
        end
    end

    assign wb_en         = q_write_reg & ~stall;
    assign branch_taken  = q_jump_neq & ~zero & ~stall;
    assign out_accept    = q_write_strobe & ~stall;
    assign branch_target = ir_pc + PC_W'(PC_STEP) + (PC_W'(imm6) << 1);

    // Fetch slot: a taken branch still loads ir but marks it invalid (squash).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (!stall) begin
            ir    <= imem_data;
            ir_pc <= pc;
            if (branch_taken) begin
                pc       <= branch_target;
                ir_valid <= 1'b0;
            end else begin
                pc       <= pc + PC_W'(PC_STEP);
                ir_valid <= 1'b1;
            end
        end
    end

    // Output port: a new write_strobe may reload in the same cycle the old value drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (out_accept) begin
            out_valid <= 1'b1;
            out_data  <= rs1_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign opcode     = ir[OPC_HI:OPC_LO];
    assign imem_addr  = pc;
    assign dmem_addr  = alu_result;
    assign dmem_wdata = rs2_data;
    assign dmem_re    = q_rom_read;
    assign dmem_we    = q_rom_write;
    assign in_ready   = q_read_strobe & ~stall_other;

endmodule

// File: tb/tb_datapath_pipe_unit.sv
// Bench for datapath_pipe_unit: acts as decoder, instruction memory and port
// partner, and compares every cycle against an instruction-level model.
module tb_datapath_pipe_unit;

    localparam int          DATA_W   = 8;
    localparam int          PC_W     = 16;
    localparam logic [15:0] RESET_PC = 16'h0010;

    logic clk, rst_n;
    logic jump_neq, write_strobe, read_strobe, rom_read, rom_write;
    logic alu_select, sel_dst_reg, rom_to_reg, write_reg;
    logic [1:0]        output_ALU;
    logic [2:0]        opcode;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata, in_data, out_data;
    logic              dmem_re, dmem_we, dmem_ready, in_valid, in_ready;
    logic              out_valid, out_ready, stall;

    datapath_pipe_unit #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .jump_neq(jump_neq), .write_strobe(write_strobe), .read_strobe(read_strobe),
        .rom_read(rom_read), .rom_write(rom_write), .alu_select(alu_select),
        .sel_dst_reg(sel_dst_reg), .rom_to_reg(rom_to_reg), .write_reg(write_reg),
        .output_ALU(output_ALU), .opcode(opcode), .imem_addr(imem_addr),
        .imem_data(imem_data), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .stall(stall)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory (aliased into 256 words).
    logic [15:0] imem [0:255];
    assign imem_data = imem[imem_addr[8:1]];

    // Bench ISA: 0 NOP, 1 R-type (funct ir[1:0]), 2 ADDI, 3 LOAD, 4 STORE, 5 IN, 6 OUT, 7 JNE.
    typedef struct packed {
        logic jn, ws, rs, rr, rw, asel, sdst, r2r, wr;
        logic [1:0] op;
    } ctl_t;

    function automatic ctl_t decode(logic [15:0] w);
        ctl_t c;
        c = '0;
        case (w[15:13])
            3'd1: begin c.sdst = 1; c.wr = 1; c.op = w[1:0]; end
            3'd2: begin c.asel = 1; c.wr = 1; end
            3'd3: begin c.rr = 1; c.r2r = 1; c.asel = 1; c.wr = 1; end
            3'd4: begin c.rw = 1; c.asel = 1; end
            3'd5: begin c.rs = 1; c.r2r = 1; c.wr = 1; end
            3'd6: c.ws = 1;
            3'd7: begin c.jn = 1; c.op = 2'b01; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic logic [15:0] enc(logic [2:0] op, logic [2:0] ra, logic [2:0] rb, logic [5:0] lo);
        return {op, 1'b0, ra, rb, lo};
    endfunction

    function automatic logic [7:0] ref_alu(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        int r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a | b;
        endcase
        return r[7:0];
    endfunction

    // Model state and scoreboard.
    logic [7:0]  regs [8];
    logic [15:0] m_pc, ex_pc, ex_ir;
    bit          ex_valid, m_out_valid, directed, last_stall;
    int          ex_age;
    logic [DATA_W-1:0] exp_q [$];
    int          n_checks, n_errors;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_ctl(ctl_t c);
        jump_neq = c.jn; write_strobe = c.ws; read_strobe = c.rs; rom_read = c.rr;
        rom_write = c.rw; alu_select = c.asel; sel_dst_reg = c.sdst;
        rom_to_reg = c.r2r; write_reg = c.wr; output_ALU = c.op;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) regs[i] = '0;
        m_pc = RESET_PC; ex_pc = '0; ex_ir = '0; ex_valid = 0;
        m_out_valid = 0; ex_age = 0; exp_q.delete();
    endtask

    task automatic reset_check(string tag);
        check({tag, "_imem_addr"}, imem_addr, RESET_PC);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_opcode"}, opcode, 0);
    endtask

    // One cycle: drive at the negedge, check 1ns later, advance model, wait next negedge.
    task automatic step();
        ctl_t c;
        int imm;
        logic [7:0] a, rs2v, b, res;
        logic [2:0] dest;
        bit in_w, mem_w, out_w, m_stall, accept;
        logic [15:0] old_pc;

        if (ex_valid) c = decode(ex_ir);
        else c = 11'($urandom);
        drive_ctl(c);
        if (directed) begin
            in_valid = (ex_age >= 2); dmem_ready = (ex_age >= 3); out_ready = (ex_age >= 2);
            in_data = 8'h3C; dmem_rdata = 8'hA5;
        end else begin
            in_valid = ($urandom_range(0, 3) != 0); dmem_ready = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data = 8'($urandom); dmem_rdata = 8'($urandom);
        end
        #1;
        a    = regs[ex_ir[11:9]];
        rs2v = regs[ex_ir[8:6]];
        imm  = ex_ir[5] ? int'(ex_ir[5:0]) - 64 : int'(ex_ir[5:0]);
        b    = c.asel ? 8'(imm) : rs2v;
        res  = ref_alu(c.op, a, b);
        dest = c.sdst ? ex_ir[5:3] : ex_ir[8:6];
        in_w  = ex_valid && c.rs && !in_valid;
        mem_w = ex_valid && (c.rr || c.rw) && !dmem_ready;
        out_w = ex_valid && c.ws && m_out_valid && !out_ready;
        m_stall = in_w || mem_w || out_w;
        last_stall = m_stall;

        check("imem_addr", imem_addr, m_pc);
        check("stall", stall, m_stall);
        check("opcode", opcode, ex_ir[15:13]);
        check("in_ready", in_ready, ex_valid && c.rs && !(mem_w || out_w));
        check("dmem_re", dmem_re, ex_valid && c.rr);
        check("dmem_we", dmem_we, ex_valid && c.rw);
        check("out_valid", out_valid, m_out_valid);
        if (ex_valid) begin
            check("alu_result", dmem_addr, res);
            check("rs2_data", dmem_wdata, rs2v);
        end
        if (m_out_valid && exp_q.size() > 0) check("out_data", out_data, exp_q[0]);

        accept = ex_valid && c.ws && !m_stall;
        if (m_out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (accept) exp_q.push_back(a);
        m_out_valid = accept || (m_out_valid && !out_ready);

        if (!m_stall) begin
            if (ex_valid && c.wr) regs[dest] = c.rs ? in_data : (c.r2r ? dmem_rdata : res);
            old_pc = ex_pc;
            ex_ir = imem[m_pc[8:1]];
            ex_pc = m_pc;
            if (ex_valid && c.jn && res != 0) begin
                ex_valid = 0;
                m_pc = 16'(int'(old_pc) + 2 + imm * 2);
            end else begin
                ex_valid = 1;
                m_pc = m_pc + 16'd2;
            end
            ex_age = 0;
        end else begin
            ex_age++;
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; directed = 1; last_stall = 0;
        drive_ctl('0);
        in_valid = 0; dmem_ready = 0; out_ready = 0; in_data = '0; dmem_rdata = '0;
        for (int i = 0; i < 256; i++) imem[i] = '0;
        imem[8'h08] = enc(3'd2, 3'd0, 3'd1, 6'd5);          // 0x10 ADDI r1 = r0 + 5
        imem[8'h09] = enc(3'd1, 3'd1, 3'd1, 6'b010001);     // 0x12 SUB  r2 = r1 - r1
        imem[8'h0A] = enc(3'd3, 3'd0, 3'd3, 6'd0);          // 0x14 LOAD r3
        imem[8'h0B] = enc(3'd5, 3'd0, 3'd4, 6'd0);          // 0x16 IN   r4
        imem[8'h0C] = enc(3'd2, 3'd0, 3'd5, 6'd17);         // 0x18 ADDI r5 = 0x11
        imem[8'h0D] = enc(3'd1, 3'd5, 3'd5, 6'b110000);     // 0x1A ADD  r6 = 0x22
        imem[8'h0E] = enc(3'd6, 3'd5, 3'd0, 6'd0);          // 0x1C OUT  r5
        imem[8'h0F] = enc(3'd6, 3'd6, 3'd0, 6'd0);          // 0x1E OUT  r6
        imem[8'h10] = enc(3'd2, 3'd1, 3'd1, 6'h3F);         // 0x20 ADDI r1 = r1 - 1
        imem[8'h11] = enc(3'd7, 3'd1, 3'd0, 6'h3E);         // 0x22 JNE  r1, r0, -2
        imem[8'h12] = enc(3'd6, 3'd3, 3'd0, 6'd0);          // 0x24 OUT  r3
        imem[8'h13] = enc(3'd6, 3'd4, 3'd0, 6'd0);          // 0x26 OUT  r4
        imem[8'h14] = enc(3'd1, 3'd2, 3'd2, 6'b111011);     // 0x28 OR   r7 = r2 | r2

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset_check("reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 90; i++) step();

        // Randomized program with random handshakes.
        directed = 0;
        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        for (int i = 0; i < 1500; i++) step();

        // Reset while an instruction is stalled (bounded search for a stall).
        for (int i = 0; i < 300 && !last_stall; i++) step();
        check("stall_before_reset", stall, 1);
        rst_n = 1'b0;
        #1 reset_check("midreset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1500; i++) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/datapath_pipe_unit.md
Name: datapath_pipe_unit

Overview:
- Parametrised, two-stage (fetch / execute) successor to the single-cycle 16-bit RISC datapath.
- Data width and PC width are configurable; instruction format stays fixed at 16 bits.
- Adds asynchronous reset, valid/ready handshakes on the I/O ports and a data-memory ready stall.
- Taken jne branches flush the fetch slot.
- Sits between the external control decoder (fed from the opcode output) and external instruction/data memories.

Parameters:
- DATA_W, 8: register, ALU and port data width; must be >= 6.
- PC_W, 16: program-counter and imem address width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- jump_neq, write_strobe, read_strobe, rom_read, rom_write, alu_select, sel_dst_reg, rom_to_reg, write_reg  in  1 each  decoded controls for the EX instruction
- output_ALU  in  2  ALU function select
- opcode  out  3  ir[15:13] of the EX-stage instruction
- imem_addr  out  PC_W  current PC
- imem_data  in  16  combinational instruction at imem_addr
- dmem_addr  out  DATA_W  ALU result
- dmem_wdata  out  DATA_W  rs2 data
- dmem_re, dmem_we  out  1  qualified rom_read / rom_write
- dmem_rdata  in  DATA_W  read data
- dmem_ready  in  1  access completes this cycle
- in_data  in  DATA_W  input port data
- in_valid  in  1  input port valid
- in_ready  out  1  input port ready
- out_data  out  DATA_W  output port data (registered)
- out_valid  out  1  output port valid
- out_ready  in  1  output port ready
- stall  out  1  pipeline held this cycle

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, ir=0, ir_valid=0, all 8 registers=0, out_valid=0, out_data=0. Reset mid-stall drops the in-flight instruction.
- IF stage: imem_addr=pc. When not stalled: ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+2 (mod 2^PC_W).
- EX stage:
  - rs1=ir[11:9], rs2=ir[8:6], dest = sel_dst_reg ? ir[5:3] : ir[8:6].
  - imm = ir[5:0] sign-extended to DATA_W; operand B = alu_select ? imm : rs2 data.
- ALU functions (output_ALU): 00 ADD, 01 SUB (A-B), 10 AND, 11 OR. Results mod 2^DATA_W; zero = (result==0).
- Qualification: all control inputs are ignored while ir_valid=0 (bubble). opcode is still driven.
- Writeback at the end of the EX cycle when write_reg, ir_valid and not stall. Data source priority: read_strobe -> in_data; else rom_to_reg -> dmem_rdata; else ALU result.
- Writeback takes effect before the next instruction's EX read, so no forwarding or interlock is needed.
- Branch: if jump_neq and !zero and not stall:
  - pc <= ir_pc + 2 + (sext(imm) << 1), computed mod 2^PC_W;
  - ir_valid <= 0, squashing the wrong-path fetch (one-cycle penalty).
- Stall = ir_valid and any of:
  - (read_strobe and !in_valid)
  - ((rom_read or rom_write) and !dmem_ready)
  - (write_strobe and out_valid and !out_ready)
- During stall: pc, ir and registers are held; no register write; no branch.
- Handshakes:
  - dmem_re/dmem_we are asserted for every cycle of a pending access; the store commits on the dmem_ready cycle.
  - in_ready = ir_valid and read_strobe and !stall_other, where stall_other excludes the in_valid term. A transfer occurs when in_valid and in_ready.
  - write_strobe accepted (not stalled): out_data <= rs1 data, out_valid <= 1.
  - out_valid clears on out_valid and out_ready, unless a new write_strobe loads the same cycle, in which case it stays 1 with the new data.
- Simultaneous events: a pending input and a pending memory access both stall; the instruction completes only when all of its conditions are met in the same cycle.

Decomposition:
- Shared package:
  - instruction field positions (OPC 15:13, RS1 11:9, RS2 8:6, RD 5:3, IMM 5:0);
  - ALU op constants ALU_ADD/SUB/AND/OR;
  - INSTR_W=16, PC_STEP=2.
- One sub-module: datapath_regfile.
  - 8 x DATA_W, two async read ports, one synchronous write port, async active-low clear.

Test Plan:
- Reset with RESET_PC=16'h0010, release: imem_addr=0x0010, then 0x0012 the next cycle; out_valid=0; registers read 0.
- ADDI r1=r0+5 followed by SUB r2=r1-r1 (DATA_W=8): r1=0x05, then r2=0x00 with zero=1; back-to-back dependency needs no stall.
- jne with imm=-2 at ir_pc=0x0020, zero=0:
  - next pc=0x001E;
  - the following EX cycle is a bubble (writeback suppressed even with write_reg=1);
  - with zero=1, fall through to 0x0022.
- Load with dmem_ready low for 3 cycles then high, dmem_rdata=0xA5: stall=1 for 3 cycles, pc frozen, then dest=0xA5.
- Input read with in_valid low 2 cycles, then in_data=0x3C valid: in_ready coincides with the transfer cycle; dest=0x3C.
- Two write_strobes (rs1=0x11, 0x22) with out_ready=0:
  - out_data=0x11 and out_valid=1 held;
  - second instruction stalls;
  - out_ready=1 for one cycle, then out_data=0x22.
